// File: rtl/alsu_pkg.sv
// Shared ALSU types: opcode encoding, datapath widths and operand sign extension.
package alsu_pkg;

  localparam int OPERAND_W = 3;
  localparam int OUT_W     = 6;
  localparam int LED_W     = 16;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  function automatic logic [OUT_W-1:0] sext(input logic [OPERAND_W-1:0] v);
    return {{(OUT_W-OPERAND_W){v[OPERAND_W-1]}}, v};
  endfunction

endpackage

// File: rtl/alsu_shifter.sv
// Combinational shift/rotate of the current ALSU result (mode 0 = shift, 1 = rotate).
module alsu_shifter
  import alsu_pkg::*;
(
  input  logic [OUT_W-1:0] i_out,
  input  logic             i_serial_in,
  input  logic             i_direction,
  input  logic             i_mode,
  output logic [OUT_W-1:0] o_result
);

  always_comb begin
    if (i_mode) begin
      o_result = i_direction ? {i_out[OUT_W-2:0], i_out[OUT_W-1]}
                             : {i_out[0], i_out[OUT_W-1:1]};
    end else begin
      o_result = i_direction ? {i_out[OUT_W-2:0], i_serial_in}
                             : {i_serial_in, i_out[OUT_W-1:1]};
    end
  end

endmodule

// File: rtl/alsu_core.sv
// Registered-input, registered-output ALSU. Define ALSU_FULL_ADDER_EN to fold cin into ADD.
module alsu_core
  import alsu_pkg::*;
#(
  parameter INPUT_PRIORITY = "A"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [OPERAND_W-1:0] A,
  input  logic signed [OPERAND_W-1:0] B,
  input  logic [2:0]                  opcode,
  input  logic                        cin,
  input  logic                        serial_in,
  input  logic                        direction,
  input  logic                        red_op_A,
  input  logic                        red_op_B,
  input  logic                        bypass_A,
  input  logic                        bypass_B,
  output logic signed [OUT_W-1:0]     out,
  output logic [LED_W-1:0]            leds
);

  localparam bit PRIO_A = (INPUT_PRIORITY == "A");

  logic signed [OPERAND_W-1:0] r_a, r_b;
  opcode_e                     r_opcode;
  logic                        r_cin, r_serial_in, r_direction;
  logic                        r_red_a, r_red_b, r_byp_a, r_byp_b;
  logic signed [OUT_W-1:0]     r_out;
  logic [LED_W-1:0]            r_leds;

  logic signed [OUT_W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [OUT_W-1:0]        w_sum, w_shift, w_out_nxt;
  logic [LED_W-1:0]        w_leds_nxt;
  logic                    w_invalid, w_sel_byp_a, w_sel_red_a, w_red_or, w_red_xor;

  assign w_a_ext = sext(r_a);
  assign w_b_ext = sext(r_b);
  assign w_prod  = w_a_ext * w_b_ext;

`ifdef ALSU_FULL_ADDER_EN
  assign w_sum = w_a_ext + w_b_ext + {{(OUT_W-1){1'b0}}, r_cin};
`else
  logic w_unused_cin;
  assign w_unused_cin = r_cin;
  assign w_sum        = w_a_ext + w_b_ext;
`endif

  assign w_invalid = (r_opcode == INVALID_6) || (r_opcode == INVALID_7) ||
                     ((r_red_a || r_red_b) && (r_opcode > XOR));

  // Simultaneous requests on both operands resolve toward INPUT_PRIORITY.
  assign w_sel_byp_a = r_byp_a && (PRIO_A || !r_byp_b);
  assign w_sel_red_a = r_red_a && (PRIO_A || !r_red_b);
  assign w_red_or    = w_sel_red_a ? (|r_a) : (|r_b);
  assign w_red_xor   = w_sel_red_a ? (^r_a) : (^r_b);

  alsu_shifter u_shifter (
    .i_out       (r_out),
    .i_serial_in (r_serial_in),
    .i_direction (r_direction),
    .i_mode      (r_opcode == ROTATE),
    .o_result    (w_shift)
  );

  always_comb begin
    w_out_nxt  = r_out;
    w_leds_nxt = '0;
    if (r_byp_a || r_byp_b) begin
      w_out_nxt = w_sel_byp_a ? w_a_ext : w_b_ext;
    end else if (w_invalid) begin
      w_out_nxt  = '0;
      w_leds_nxt = ~r_leds;
    end else begin
      case (r_opcode)
        OR: begin
          if (r_red_a || r_red_b) w_out_nxt = {{(OUT_W-1){1'b0}}, w_red_or};
          else                    w_out_nxt = {{(OUT_W-OPERAND_W){1'b0}}, r_a | r_b};
        end
        XOR: begin
          if (r_red_a || r_red_b) w_out_nxt = {{(OUT_W-1){1'b0}}, w_red_xor};
          else                    w_out_nxt = {{(OUT_W-OPERAND_W){1'b0}}, r_a ^ r_b};
        end
        ADD:           w_out_nxt = w_sum;
        MULT:          w_out_nxt = w_prod;
        SHIFT, ROTATE: w_out_nxt = w_shift;
        default:       w_out_nxt = '0;
      endcase
    end
  end

  // Input capture stage and result stage share the same edge; result uses last capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_opcode    <= OR;
      r_cin       <= 1'b0;
      r_serial_in <= 1'b0;
      r_direction <= 1'b0;
      r_red_a     <= 1'b0;
      r_red_b     <= 1'b0;
      r_byp_a     <= 1'b0;
      r_byp_b     <= 1'b0;
      r_out       <= '0;
      r_leds      <= '0;
    end else begin
      r_a         <= A;
      r_b         <= B;
      r_opcode    <= opcode_e'(opcode);
      r_cin       <= cin;
      r_serial_in <= serial_in;
      r_direction <= direction;
      r_red_a     <= red_op_A;
      r_red_b     <= red_op_B;
      r_byp_a     <= bypass_A;
      r_byp_b     <= bypass_B;
      r_out       <= w_out_nxt;
      r_leds      <= w_leds_nxt;
    end
  end

  assign out  = r_out;
  assign leds = r_leds;

endmodule

// File: tb/tb_alsu_core.sv
// Directed self-checking bench for alsu_core: inputs change on negedge, outputs sampled on negedge.
module tb_alsu_core;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [2:0] A = '0, B = '0;
  logic [2:0]        opcode = '0;
  logic              cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
  logic              red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
  logic signed [5:0] out;
  logic [15:0]       leds;

  int checks = 0;
  int errors = 0;

  alsu_core #(.INPUT_PRIORITY("A")) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    opcode = 3'd0; A = '0; B = '0; cin = 1'b0; serial_in = 1'b0; direction = 1'b0;
    red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
  endtask

  // Builds a known out value by shifting it in MSB-first from zero; out equals v one tick after return.
  task automatic load_out(input logic [5:0] v);
    idle();
    tick();
    for (int i = 5; i >= 0; i--) begin
      opcode = 3'd4; direction = 1'b1; serial_in = v[i];
      tick();
    end
  endtask

  task automatic test_reset();
    bypass_A = 1'b1; A = 3'b011;
    tick(); tick(); tick();
    checks++; if (out !== 6'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL reset_leds: got %h expected 0000", leds); end
    rst = 1'b1;
    tick();
    checks++; if (out !== 6'h00) begin errors++; $display("FAIL first_edge_capture_only: got %h expected 00", out); end
    tick();
    checks++; if (out !== 6'h03) begin errors++; $display("FAIL first_valid_out: got %h expected 03", out); end
    idle();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [12:0] vec [11];
    logic [5:0]  exp [11];
    vec = '{{3'd0,3'b011,3'b100,4'b0000}, {3'd1,3'b101,3'b011,4'b0000},
            {3'd0,3'b100,3'b000,4'b1000}, {3'd1,3'b111,3'b011,4'b0100},
            {3'd1,3'b111,3'b000,4'b1000}, {3'd0,3'b000,3'b111,4'b1100},
            {3'd3,3'b101,3'b010,4'b0011}, {3'd3,3'b100,3'b100,4'b0000},
            {3'd3,3'b100,3'b011,4'b0000}, {3'd2,3'b100,3'b100,4'b0000},
            {3'd6,3'b000,3'b010,4'b0001}};
    exp = '{6'h07, 6'h06, 6'h01, 6'h00, 6'h01, 6'h00, 6'h3D, 6'h10, 6'h34, 6'h38, 6'h02};
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) begin
        {opcode, A, B, red_op_A, red_op_B, bypass_A, bypass_B} = vec[i];
      end else begin
        idle();
      end
      tick();
      if (i >= 1) begin
        checks++;
        if (out !== exp[i-1]) begin
          errors++; $display("FAIL stream_out[%0d]: got %h expected %h", i-1, out, exp[i-1]);
        end
        checks++;
        if (leds !== 16'h0000) begin
          errors++; $display("FAIL stream_leds[%0d]: got %h expected 0000", i-1, leds);
        end
      end
    end
    tick();
  endtask

  task automatic test_add_mult();
    logic [5:0] add_exp;
`ifdef ALSU_FULL_ADDER_EN
    add_exp = 6'h06;
`else
    add_exp = 6'h05;
`endif
    opcode = 3'd2; A = 3'sd3; B = 3'sd2; cin = 1'b1;
    tick(); tick();
    checks++; if (out !== add_exp) begin errors++; $display("FAIL add_cin: got %h expected %h", out, add_exp); end
    opcode = 3'd3; A = 3'sd3; B = -3'sd2; cin = 1'b0;
    tick();
    checks++; if (out !== add_exp) begin errors++; $display("FAIL mult_latency: got %h expected %h", out, add_exp); end
    tick();
    checks++; if (out !== 6'h3A) begin errors++; $display("FAIL mult_neg: got %h expected 3a", out); end
  endtask

  task automatic test_invalid();
    logic [15:0] led_exp [4];
    led_exp = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    opcode = 3'd6; A = 3'b011; B = 3'b100;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) opcode = 3'd0;
      tick();
      checks++; if (out !== 6'h00) begin errors++; $display("FAIL invalid_out[%0d]: got %h expected 00", i, out); end
      checks++;
      if (leds !== led_exp[i]) begin
        errors++; $display("FAIL invalid_leds[%0d]: got %h expected %h", i, leds, led_exp[i]);
      end
    end
    tick();
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL leave_invalid_leds: got %h expected 0000", leds); end
    checks++; if (out !== 6'h07) begin errors++; $display("FAIL leave_invalid_out: got %h expected 07", out); end
    opcode = 3'd7;
    tick();
    opcode = 3'd0;
    tick();
    checks++; if (leds !== 16'hFFFF) begin errors++; $display("FAIL op7_leds: got %h expected ffff", leds); end
    checks++; if (out !== 6'h00) begin errors++; $display("FAIL op7_out: got %h expected 00", out); end
    tick();
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL op7_exit_leds: got %h expected 0000", leds); end
    checks++; if (out !== 6'h07) begin errors++; $display("FAIL op7_exit_out: got %h expected 07", out); end
  endtask

  task automatic test_redop_invalid();
    opcode = 3'd2; A = 3'b011; B = 3'b010; red_op_A = 1'b1;
    tick(); tick();
    checks++; if (out !== 6'h00) begin errors++; $display("FAIL redop_add_out: got %h expected 00", out); end
    checks++; if (leds !== 16'hFFFF) begin errors++; $display("FAIL redop_add_leds0: got %h expected ffff", leds); end
    tick();
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL redop_add_leds1: got %h expected 0000", leds); end
    bypass_B = 1'b1; B = 3'b111;
    tick(); tick();
    checks++; if (out !== 6'h3F) begin errors++; $display("FAIL redop_bypass_out: got %h expected 3f", out); end
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL redop_bypass_leds: got %h expected 0000", leds); end
    idle();
    tick();
  endtask

  task automatic test_shift_rotate();
    load_out(6'b100001);
    opcode = 3'd4; direction = 1'b1; serial_in = 1'b0;
    tick();
    checks++; if (out !== 6'b100001) begin errors++; $display("FAIL shift_preload: got %b expected 100001", out); end
    opcode = 3'd5; direction = 1'b0;
    tick();
    checks++; if (out !== 6'b000010) begin errors++; $display("FAIL shift_left: got %b expected 000010", out); end
    opcode = 3'd4; direction = 1'b0; serial_in = 1'b1;
    tick();
    checks++; if (out !== 6'b000001) begin errors++; $display("FAIL rotate_right: got %b expected 000001", out); end
    opcode = 3'd5; direction = 1'b1; serial_in = 1'b0;
    tick();
    checks++; if (out !== 6'b100000) begin errors++; $display("FAIL shift_right: got %b expected 100000", out); end
    idle();
    tick();
    checks++; if (out !== 6'b000001) begin errors++; $display("FAIL rotate_left: got %b expected 000001", out); end
  endtask

  task automatic test_reset_mid();
    load_out(6'h15);
    idle();
    tick();
    checks++; if (out !== 6'h15) begin errors++; $display("FAIL mid_preload: got %h expected 15", out); end
    opcode = 3'd3; A = 3'b011; B = 3'b011;
    rst = 1'b0;
    #1;
    checks++; if (out !== 6'h00) begin errors++; $display("FAIL mid_reset_out: got %h expected 00", out); end
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL mid_reset_leds: got %h expected 0000", leds); end
    idle();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (out !== 6'h00) begin errors++; $display("FAIL mid_reset_discard: got %h expected 00", out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    test_reset();
    test_back_to_back();
    test_add_mult();
    test_invalid();
    test_redop_invalid();
    test_shift_rotate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
